// File: rtl/de0_nano_demo_top.sv
// DE0-Nano serial-system-bus demo top.
// A debounced KEY[1] press runs one bit-serial bus transaction from an internal
// master to one of three slaves (two 16x8 register memories and a UART bridge)
// and shows the transferred byte on LED. Bridge writes leave as two UART bytes.
// Optional build macro DEMO_UART_PARITY_EN adds an even-parity bit to every UART byte.
module de0_nano_demo_top #(
    parameter int         BAUD_DIV        = 434,
    parameter int         DEBOUNCE_CYCLES = 16,
    parameter logic [3:0] DEMO_ADDR       = 4'h0
) (
    input  logic       CLOCK_50,
    input  logic [1:0] KEY,
    input  logic [3:0] SW,
    output logic [7:0] LED,
    input  logic       GPIO_0_BRIDGE_M_RX,
    output logic       GPIO_0_BRIDGE_M_TX,
    input  logic       GPIO_0_BRIDGE_S_RX,
    output logic       GPIO_0_BRIDGE_S_TX
);

`ifdef DEMO_UART_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int TOTAL_BITS = 2 * FRAME_BITS;
    localparam int TXB_W      = $clog2(TOTAL_BITS);
    localparam int BAUD_W     = $clog2(BAUD_DIV);
    localparam int DB_W       = $clog2(DEBOUNCE_CYCLES + 1);

    typedef enum logic [2:0] {S_IDLE, S_SEL, S_ADDR, S_WDATA, S_RDATA, S_DONE} state_t;

`ifdef DEMO_UART_PARITY_EN
    function automatic logic even_parity(input logic [7:0] b);
        return ^b;
    endfunction

    function automatic logic [FRAME_BITS-1:0] uart_frame(input logic [7:0] b);
        return {1'b1, even_parity(b), b, 1'b0};
    endfunction
`else
    function automatic logic [FRAME_BITS-1:0] uart_frame(input logic [7:0] b);
        return {1'b1, b, 1'b0};
    endfunction
`endif

    logic w_clk;
    logic w_rst;
    logic w_unused_rx;
    assign w_clk       = CLOCK_50;
    assign w_rst       = ~KEY[0];
    assign w_unused_rx = GPIO_0_BRIDGE_M_RX ^ GPIO_0_BRIDGE_S_RX;

    // key conditioning
    logic            r_key_meta, r_key_sync, r_armed, r_trig;
    logic [DB_W-1:0] r_db_cnt;
    // master FSM
    state_t          r_state;
    logic [2:0]      r_cnt;
    logic            r_is_read;
    logic [1:0]      r_target, r_last_slave;
    logic [7:0]      r_wdata, r_m_shift, r_m_rdata, r_led;
    // slaves
    logic [3:0]      r_s_addr;
    logic [7:0]      r_s_data, r_s_out, r_shadow;
    logic [7:0]      r_mem1 [16];
    logic [7:0]      r_mem2 [16];
    // bridge UART
    logic                  r_tx, r_tx_busy;
    logic [TOTAL_BITS-1:0] r_tx_shift;
    logic [TXB_W-1:0]      r_tx_bits;
    logic [BAUD_W-1:0]     r_baud;

    logic                  w_bus;
    logic [3:0]            w_addr_full;
    logic [7:0]            w_rd_byte;
    logic                  w_uart_load;
    logic [TOTAL_BITS-1:0] w_frame;

    // Serial bus line: master drives address/write data, slave drives read data.
    always_comb begin
        w_bus = 1'b1;
        case (r_state)
            S_ADDR, S_WDATA: w_bus = r_m_shift[0];
            S_RDATA:         w_bus = r_s_out[0];
            default:         w_bus = 1'b1;
        endcase
    end

    // Slave-side decode: assembled address and the byte a read returns.
    always_comb begin
        w_addr_full = {w_bus, r_s_addr[3:1]};
        case (r_target)
            2'd1:    w_rd_byte = r_mem1[w_addr_full];
            2'd2:    w_rd_byte = r_mem2[w_addr_full];
            default: w_rd_byte = r_shadow;
        endcase
    end

    assign w_uart_load = (r_state == S_DONE) && !r_is_read && (r_target == 2'd3);
    assign w_frame     = {uart_frame(r_s_data), uart_frame({4'h0, r_s_addr})};

    // KEY[1] synchronizer and debouncer; one trigger per press, re-armed on release.
    always_ff @(posedge w_clk or posedge w_rst) begin
        if (w_rst) begin
            r_key_meta <= 1'b1;
            r_key_sync <= 1'b1;
            r_armed    <= 1'b1;
            r_trig     <= 1'b0;
            r_db_cnt   <= {DB_W{1'b0}};
        end else begin
            r_key_meta <= KEY[1];
            r_key_sync <= r_key_meta;
            r_trig     <= 1'b0;
            if (r_key_sync) begin
                r_armed  <= 1'b1;
                r_db_cnt <= {DB_W{1'b0}};
            end else if (r_armed) begin
                if (r_db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                    r_trig   <= 1'b1;
                    r_armed  <= 1'b0;
                    r_db_cnt <= {DB_W{1'b0}};
                end else begin
                    r_db_cnt <= r_db_cnt + 1'b1;
                end
            end
        end
    end

    // Bus master FSM: decode, shift address and data LSB first, latch result on LED.
    always_ff @(posedge w_clk or posedge w_rst) begin
        if (w_rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= 3'd0;
            r_is_read    <= 1'b0;
            r_target     <= 2'd1;
            r_last_slave <= 2'd1;
            r_wdata      <= 8'h00;
            r_m_shift    <= 8'h00;
            r_m_rdata    <= 8'h00;
            r_led        <= 8'h00;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (r_trig) begin
                        r_wdata   <= {4{SW[1:0]}};
                        r_is_read <= (SW[3:2] == 2'b11);
                        r_target  <= (SW[3:2] == 2'b11) ? r_last_slave : (SW[3:2] + 2'd1);
                        r_state   <= S_SEL;
                    end
                end
                S_SEL: begin
                    // a bridge write waits here until the previous UART frame has left
                    if (!((r_target == 2'd3) && !r_is_read && r_tx_busy)) begin
                        r_m_shift <= {4'h0, DEMO_ADDR};
                        r_cnt     <= 3'd0;
                        r_state   <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    r_m_shift <= {1'b0, r_m_shift[7:1]};
                    if (r_cnt == 3'd3) begin
                        r_cnt <= 3'd0;
                        if (r_is_read) begin
                            r_state <= S_RDATA;
                        end else begin
                            r_m_shift <= r_wdata;
                            r_state   <= S_WDATA;
                        end
                    end else begin
                        r_cnt <= r_cnt + 3'd1;
                    end
                end
                S_WDATA: begin
                    r_m_shift <= {1'b0, r_m_shift[7:1]};
                    r_cnt     <= r_cnt + 3'd1;
                    if (r_cnt == 3'd7) begin
                        r_state <= S_DONE;
                    end
                end
                S_RDATA: begin
                    r_m_rdata <= {w_bus, r_m_rdata[7:1]};
                    r_cnt     <= r_cnt + 3'd1;
                    if (r_cnt == 3'd7) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (r_is_read) begin
                        r_led <= r_m_rdata;
                    end else begin
                        r_led        <= r_wdata;
                        r_last_slave <= r_target;
                    end
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Slave side: collect address and write data from the bus, serve reads, commit writes.
    always_ff @(posedge w_clk or posedge w_rst) begin
        if (w_rst) begin
            r_s_addr <= 4'h0;
            r_s_data <= 8'h00;
            r_s_out  <= 8'h00;
            r_shadow <= 8'h00;
            for (int i = 0; i < 16; i++) begin
                r_mem1[i] <= 8'h00;
                r_mem2[i] <= 8'h00;
            end
        end else begin
            case (r_state)
                S_ADDR: begin
                    r_s_addr <= w_addr_full;
                    if ((r_cnt == 3'd3) && r_is_read) begin
                        r_s_out <= w_rd_byte;
                    end
                end
                S_WDATA: r_s_data <= {w_bus, r_s_data[7:1]};
                S_RDATA: r_s_out  <= {1'b0, r_s_out[7:1]};
                S_DONE: begin
                    if (!r_is_read) begin
                        case (r_target)
                            2'd1:    r_mem1[r_s_addr] <= r_s_data;
                            2'd2:    r_mem2[r_s_addr] <= r_s_data;
                            2'd3:    r_shadow <= r_s_data;
                            default: r_shadow <= r_shadow;
                        endcase
                    end
                end
                default: r_s_addr <= r_s_addr;
            endcase
        end
    end

    // Bridge UART transmitter: sends the address byte then the data byte back to back.
    always_ff @(posedge w_clk or posedge w_rst) begin
        if (w_rst) begin
            r_tx       <= 1'b1;
            r_tx_busy  <= 1'b0;
            r_tx_shift <= {TOTAL_BITS{1'b1}};
            r_tx_bits  <= {TXB_W{1'b0}};
            r_baud     <= {BAUD_W{1'b0}};
        end else if (w_uart_load) begin
            r_tx       <= w_frame[0];
            r_tx_busy  <= 1'b1;
            r_tx_shift <= {1'b1, w_frame[TOTAL_BITS-1:1]};
            r_tx_bits  <= TXB_W'(TOTAL_BITS - 1);
            r_baud     <= {BAUD_W{1'b0}};
        end else if (r_tx_busy) begin
            if (r_baud == BAUD_W'(BAUD_DIV - 1)) begin
                r_baud <= {BAUD_W{1'b0}};
                if (r_tx_bits == {TXB_W{1'b0}}) begin
                    r_tx_busy <= 1'b0;
                    r_tx      <= 1'b1;
                end else begin
                    r_tx       <= r_tx_shift[0];
                    r_tx_shift <= {1'b1, r_tx_shift[TOTAL_BITS-1:1]};
                    r_tx_bits  <= r_tx_bits - 1'b1;
                end
            end else begin
                r_baud <= r_baud + 1'b1;
            end
        end else begin
            r_tx <= 1'b1;
        end
    end

    assign LED                = r_led;
    assign GPIO_0_BRIDGE_S_TX = r_tx;
    assign GPIO_0_BRIDGE_M_TX = 1'b1;

endmodule

// File: tb/tb_de0_nano_demo_top.sv
// Directed self-checking bench for de0_nano_demo_top.
module tb_de0_nano_demo_top;

    logic       clk;
    logic [1:0] key;
    logic [3:0] sw;
    logic [7:0] led;
    logic       m_rx, m_tx, s_rx, s_tx;
    int         n_tests;
    int         n_fail;

    de0_nano_demo_top dut (
        .CLOCK_50           (clk),
        .KEY                (key),
        .SW                 (sw),
        .LED                (led),
        .GPIO_0_BRIDGE_M_RX (m_rx),
        .GPIO_0_BRIDGE_M_TX (m_tx),
        .GPIO_0_BRIDGE_S_RX (s_rx),
        .GPIO_0_BRIDGE_S_TX (s_tx)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Press KEY[1] for 100 cycles with the given switches, wait, then check LED.
    task automatic do_txn(input logic [3:0] swv, input logic [7:0] exp, input string name);
        sw     = swv;
        key[1] = 1'b0;
        repeat (100) @(negedge clk);
        key[1] = 1'b1;
        repeat (100) @(negedge clk);
        n_tests++;
        if (led !== exp) begin
            n_fail++;
            $display("FAIL %s: LED=%h expected %h", name, led, exp);
        end
    endtask

    // Wait (bounded) for the bridge TX start bit; returns 1 on success.
    task automatic wait_start(output logic found, input string name);
        found = 1'b0;
        for (int t = 0; t < 3000 && !found; t++) begin
            @(negedge clk);
            if (s_tx === 1'b0) found = 1'b1;
        end
        n_tests++;
        if (!found) begin
            n_fail++;
            $display("FAIL %s: no UART start bit seen, got none expected one within 3000 cycles", name);
        end
    endtask

    task automatic test_reset;
        int lows;
        key = 2'b10; sw = 4'b0000; m_rx = 1'b0; s_rx = 1'b0;
        repeat (100) @(negedge clk);
        n_tests++;
        if (led !== 8'h00 || s_tx !== 1'b1 || m_tx !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_hold: LED=%h S_TX=%b M_TX=%b expected 00 1 1", led, s_tx, m_tx);
        end
        key[0] = 1'b1;
        lows = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            m_rx = ~m_rx; s_rx = ~s_rx;
            if (s_tx !== 1'b1) lows++;
        end
        n_tests++;
        if (led !== 8'h00 || lows != 0) begin
            n_fail++;
            $display("FAIL reset_release: LED=%h S_TX low cycles=%0d expected 00 and 0", led, lows);
        end
    endtask

    task automatic test_slaves;
        do_txn(4'b0001, 8'h55, "wr_s1_55");
        do_txn(4'b1100, 8'h55, "rd_s1_55");
        do_txn(4'b0110, 8'hAA, "wr_s2_AA");
        do_txn(4'b1100, 8'hAA, "rd_s2_AA");
        do_txn(4'b0000, 8'h00, "wr_s1_00");
        do_txn(4'b1100, 8'h00, "rd_s1_00");
        do_txn(4'b0011, 8'hFF, "wr_s1_FF");
        do_txn(4'b1100, 8'hFF, "rd_s1_FF");
    endtask

    // Bridge write with KEY[1] held through the whole frame: decode and time the bits.
    task automatic test_bridge;
        logic        found;
        logic [19:0] bits, exp_bits;
        int          late_lows;
        sw = 4'b1001; key[1] = 1'b0;
        exp_bits = {1'b1, 8'h55, 1'b0, 1'b1, 8'h00, 1'b0};
        bits = 20'h0;
        wait_start(found, "bridge_start");
        if (found) begin
            for (int r = 1; r <= 8690; r++) begin
                @(negedge clk);
                if ((r % 434) == 217) bits[r / 434] = s_tx;
                if (r == 4773 && s_tx !== 1'b0) begin
                    n_fail++;
                    $display("FAIL bridge_bit_end: S_TX=%b at cycle 4773 expected 0", s_tx);
                end
                if (r == 4774 && s_tx !== 1'b1) begin
                    n_fail++;
                    $display("FAIL bridge_bit_next: S_TX=%b at cycle 4774 expected 1", s_tx);
                end
                if (r == 4773 || r == 4774) n_tests++;
                if (r == 8690) begin
                    n_tests++;
                    if (s_tx !== 1'b1) begin
                        n_fail++;
                        $display("FAIL bridge_idle: S_TX=%b after frame expected 1", s_tx);
                    end
                end
            end
            n_tests++;
            if (bits !== exp_bits) begin
                n_fail++;
                $display("FAIL bridge_frame: bits=%h expected %h", bits, exp_bits);
            end
        end
        key[1] = 1'b1;
        late_lows = 0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (s_tx !== 1'b1) late_lows++;
        end
        n_tests++;
        if (led !== 8'h55 || late_lows != 0) begin
            n_fail++;
            $display("FAIL bridge_led: LED=%h extra TX low cycles=%0d expected 55 and 0", led, late_lows);
        end
    endtask

    // Reading the bridge returns the shadow byte and produces no UART traffic.
    task automatic test_bridge_read;
        int lows;
        lows = 0;
        sw = 4'b1100; key[1] = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (i == 100) key[1] = 1'b1;
            if (s_tx !== 1'b1) lows++;
        end
        n_tests++;
        if (led !== 8'h55 || lows != 0) begin
            n_fail++;
            $display("FAIL bridge_read: LED=%h TX low cycles=%0d expected 55 and 0", led, lows);
        end
    endtask

    // Second bridge write during a UART send stalls until the line is free.
    task automatic test_stall;
        logic found;
        sw = 4'b1001; key[1] = 1'b0;
        wait_start(found, "stall_first_start");
        for (int r = 1; r <= 8800; r++) begin
            @(negedge clk);
            if (r == 100) key[1] = 1'b1;
            if (r == 1000) begin sw = 4'b1010; key[1] = 1'b0; end
            if (r == 1100) key[1] = 1'b1;
            if (r == 2000) begin
                n_tests++;
                if (led !== 8'h55) begin
                    n_fail++;
                    $display("FAIL stall_hold: LED=%h expected 55", led);
                end
            end
        end
        n_tests++;
        if (led !== 8'hAA) begin
            n_fail++;
            $display("FAIL stall_done: LED=%h expected AA", led);
        end
        repeat (9000) @(negedge clk);
        n_tests++;
        if (s_tx !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_idle: S_TX=%b expected 1", s_tx);
        end
        do_txn(4'b1100, 8'hAA, "stall_rd_shadow");
    endtask

    // KEY[0] mid-frame drops TX high at once and clears all state.
    task automatic test_mid_reset;
        logic found;
        int   lows;
        sw = 4'b1001; key[1] = 1'b0;
        wait_start(found, "rst_start");
        for (int r = 1; r < 1000; r++) begin
            @(negedge clk);
            if (r == 100) key[1] = 1'b1;
        end
        key[1] = 1'b1;
        n_tests++;
        if (s_tx !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_pre: S_TX=%b before reset expected 0", s_tx);
        end
        key[0] = 1'b0;
        #1;
        n_tests++;
        if (s_tx !== 1'b1 || led !== 8'h00) begin
            n_fail++;
            $display("FAIL rst_immediate: S_TX=%b LED=%h expected 1 00", s_tx, led);
        end
        repeat (20) @(negedge clk);
        key[0] = 1'b1;
        lows = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (s_tx !== 1'b1) lows++;
        end
        n_tests++;
        if (lows != 0) begin
            n_fail++;
            $display("FAIL rst_no_resume: TX low cycles=%0d expected 0", lows);
        end
        do_txn(4'b1100, 8'h00, "rst_rd_s1_cleared");
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        key = 2'b10; sw = 4'b0000; m_rx = 1'b0; s_rx = 1'b0;
        test_reset();
        test_slaves();
        test_bridge();
        test_bridge_read();
        test_stall();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/de0_nano_demo_top.md
Name: de0_nano_demo_top

Overview:
- Board-level demo top for the DE0-Nano serial-system-bus demo.
- Takes switch and button input, runs one bit-serial bus transaction per KEY[1] press from an internal master to one of three slaves, and shows the transferred byte on LED.
- Slaves 1 and 2 are 16x8 register memories.
- Slave 3 is a bus bridge that forwards every write as a two-byte UART frame on GPIO_0_BRIDGE_S_TX.

Parameters:
- BAUD_DIV, 434, clocks per UART bit (115200 baud at 50 MHz).
- DEBOUNCE_CYCLES, 16, consecutive synchronized-low cycles before a KEY[1] press is accepted.
- DEMO_ADDR, 4'h0, fixed slave address used by every demo transaction.

Ports:
- CLOCK_50  in  1  sole clock, 50 MHz.
- KEY  in  2  active-low buttons; KEY[0]=reset button, KEY[1]=execute.
- SW  in  4  SW[3:2]=mode, SW[1:0]=data seed.
- LED  out  8  byte from the last completed transaction.
- GPIO_0_BRIDGE_M_RX  in  1  bridge-master UART RX; unused, ignored.
- GPIO_0_BRIDGE_M_TX  out  1  bridge-master UART TX; tied idle high.
- GPIO_0_BRIDGE_S_RX  in  1  bridge-slave UART RX; unused, ignored.
- GPIO_0_BRIDGE_S_TX  out  1  bridge-slave UART TX, idle high.

Interface note: one clock (CLOCK_50); reset is asynchronous and active-high. The internal reset rst = ~KEY[0] is applied directly as an async clear to all flops; it is not synchronized.

Behaviour:
- Reset values:
  - LED=0x00; both UART TX=1.
  - FSM=IDLE; last_slave=1.
  - All slave memories 0x00; bridge shadow=0x00.
  - Reset mid-transaction or mid-UART-frame aborts it; TX returns high immediately.
- KEY[1]:
  - 2-FF synchronized, then debounced: after DEBOUNCE_CYCLES consecutive low samples, emit a one-cycle trigger.
  - No further trigger until KEY[1] has been released (synchronized high).
  - A trigger while the FSM is not IDLE is dropped.
- On trigger, sample SW:
  - wdata = {SW[1:0],SW[1:0],SW[1:0],SW[1:0]}.
  - Mode 00 = write slave 1; 01 = write slave 2; 10 = write slave 3 (bridge); 11 = read from last_slave.
  - Each write sets last_slave to its target.
- FSM states: IDLE -> SEL (1 cycle, slave decode) -> ADDR (4 cycles, DEMO_ADDR shifted LSB first) -> WDATA or RDATA (8 cycles, LSB first) -> DONE (1 cycle) -> IDLE.
- Latency: write and read each complete in 14 cycles after the trigger.
- At DONE, LED <= transferred byte: wdata for writes, read byte for reads.
- Slaves 1 and 2: the write stores the byte at DEMO_ADDR; the read returns the stored byte.
- Slave 3 (bridge):
  - A write stores the shadow byte and enqueues the frame byte0={4'h0,DEMO_ADDR}, then byte1=wdata.
  - A read returns the shadow byte; no UART activity on read.
  - If the UART is still busy when a bridge write reaches SEL, the FSM holds in SEL until the UART is idle.
- UART TX framing:
  - 8N1, LSB first: start bit 0, 8 data bits, stop bit 1; each bit lasts BAUD_DIV cycles.
  - The two bytes are sent back to back, 20*BAUD_DIV cycles total.
- GPIO_0_BRIDGE_M_TX is constant 1. RX inputs have no effect.

Optional Feature:
- Macro DEMO_UART_PARITY_EN.
- Defined: every UART byte carries an even-parity bit between data bit 7 and the stop bit (11-bit frames, 22*BAUD_DIV cycles per bridge write).
- Undefined: plain 8N1 as above.

Test Plan:
- Hold KEY[0]=0 for 100 cycles, then release -> LED=0x00, S_TX=1, no S_TX toggles.
- SW=0001, press KEY[1] 100 cycles -> LED=0x55 within 2000 cycles; then SW=1100, press -> LED=0x55 (read from slave 1).
- SW=0110, press -> LED=0xAA; then SW=1100, press -> LED=0xAA (read from slave 2).
- SW=0000, press -> LED=0x00; then SW=0011, press -> LED=0xFF.
- SW=1001, press -> LED=0x55, and S_TX carries frames 0x00 then 0x55, each bit 434 cycles wide, back to idle within 10000 cycles.
- Second KEY[1] press during a transaction or during a bridge UART send -> ignored or stalled as specified, with no corruption of LED or memory; KEY[0] pressed mid-frame -> S_TX high at once, LED=0x00.
